// File: rtl/i2s_tx.sv
// Philips I2S transmitter: buffers one mono sample per frame and serialises it
// to both channels, generating BCLK/LRCLK from the system clock.
module i2s_tx #(
  parameter int WIDTH     = 24,
  parameter int SLOT_BITS = 32,
  parameter int HALF_DIV  = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             i2s_bclk,
  output logic             i2s_lrclk,
  output logic             i2s_sdata,
  output logic             frame_start,
  output logic             underrun,
  output logic [7:0]       overflow_cnt
);

  localparam int FRAME = 2 * SLOT_BITS;
  localparam int HW    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int BW    = $clog2(FRAME);
  localparam int SW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME - 1);

  logic [HW-1:0]    half_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_nxt;
  logic [BW-1:0]    p_nxt;
  logic             lr_nxt;
  logic             sdata_nxt;
  logic [SW-1:0]    sel;
  logic             tick;
  logic             fall;
  logic             boundary;
  logic [WIDTH-1:0] hold_reg;
  logic [WIDTH-1:0] last_reg;
  logic [WIDTH-1:0] shifter;

  assign tick     = (half_cnt == HALF_LAST);
  assign fall     = tick && i2s_bclk;
  assign boundary = fall && (bit_cnt == BIT_LAST);

  // Position within the slot after the coming falling edge; one-bit I2S delay
  // puts the MSB at p=1. Modular index arithmetic keeps WIDTH-p in range.
  always_comb begin
    bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
    lr_nxt    = (bit_nxt >= BW'(SLOT_BITS));
    p_nxt     = lr_nxt ? bit_nxt - BW'(SLOT_BITS) : bit_nxt;
    sel       = SW'(WIDTH) - SW'(p_nxt);
    sdata_nxt = 1'b0;
    if (p_nxt != '0 && p_nxt <= BW'(WIDTH))
      sdata_nxt = shifter[sel];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      half_cnt  <= '0;
      i2s_bclk  <= 1'b0;
      bit_cnt   <= BIT_LAST;
      i2s_lrclk <= 1'b1;
      i2s_sdata <= 1'b0;
    end else begin
      if (tick) begin
        half_cnt <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        half_cnt <= half_cnt + HW'(1);
      end
      if (fall) begin
        bit_cnt   <= bit_nxt;
        i2s_lrclk <= lr_nxt;
        i2s_sdata <= sdata_nxt;
      end
    end
  end

  // A boundary load frees the holding slot in the same cycle, so a sample
  // arriving exactly then is captured rather than counted as dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sample_ready <= 1'b1;
      hold_reg     <= '0;
      last_reg     <= '0;
      shifter      <= '0;
      frame_start  <= 1'b0;
      underrun     <= 1'b0;
      overflow_cnt <= 8'd0;
    end else begin
      frame_start <= boundary;
      underrun    <= boundary && sample_ready;
      if (boundary) begin
        if (!sample_ready) begin
          shifter  <= hold_reg;
          last_reg <= hold_reg;
        end else begin
          shifter <= last_reg;
        end
      end
      if (sample_valid && (sample_ready || boundary)) begin
        hold_reg     <= sample_in;
        sample_ready <= 1'b0;
      end else if (boundary) begin
        sample_ready <= 1'b1;
      end else if (sample_valid && overflow_cnt != 8'hFF) begin
        overflow_cnt <= overflow_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx (HALF_DIV=2): checks BCLK timing, frame contents,
// underrun/overflow reporting, boundary capture and asynchronous reset.
`timescale 1ns/1ps
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rstn;
  logic [23:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        frame_start;
  logic        underrun;
  logic [7:0]  overflow_cnt;

  int passed = 0;
  int total  = 0;

  i2s_tx #(.WIDTH(24), .SLOT_BITS(32), .HALF_DIV(2)) dut (
    .clk(clk),
    .rstn(rstn),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .i2s_bclk(i2s_bclk),
    .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata),
    .frame_start(frame_start),
    .underrun(underrun),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic [23:0] val);
    sample_valid = 1'b1;
    sample_in    = val;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic waitFrame(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < 600);
  endtask

  // Called in the frame_start cycle; records sdata/lrclk at every BCLK fall.
  task automatic collectFrame(input logic push, input logic [23:0] val,
                              output logic [63:0] d, output logic [63:0] lr,
                              output logic ur_seen);
    int   k;
    logic prev;
    d       = '0;
    lr      = '0;
    d[63]   = i2s_sdata;
    lr[63]  = i2s_lrclk;
    k       = 1;
    ur_seen = 1'b0;
    for (int c = 0; c < 300 && k < 64; c++) begin
      prev = i2s_bclk;
      if (c == 0 && push) begin
        sample_valid = 1'b1;
        sample_in    = val;
      end
      tick();
      sample_valid = 1'b0;
      ur_seen |= underrun;
      if (prev && !i2s_bclk) begin
        d[63-k]  = i2s_sdata;
        lr[63-k] = i2s_lrclk;
        k++;
      end
    end
    checkOutput("bits_collected", 64'(k), 64'd64);
  endtask

  initial begin
    int          n;
    logic [63:0] d;
    logic [63:0] lr;
    logic        ur;

    rstn         = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    repeat (3) tick();
    checkOutput("rst_bclk", i2s_bclk, 1'b0);
    checkOutput("rst_lrclk", i2s_lrclk, 1'b1);
    checkOutput("rst_sdata", i2s_sdata, 1'b0);
    checkOutput("rst_ready", sample_ready, 1'b1);
    checkOutput("rst_fs", frame_start, 1'b0);
    checkOutput("rst_ur", underrun, 1'b0);
    checkOutput("rst_ovf", overflow_cnt, 8'd0);

    rstn = 1'b1;
    tick();
    checkOutput("cyc1_bclk", i2s_bclk, 1'b0);
    tick();
    checkOutput("cyc2_bclk", i2s_bclk, 1'b1);
    tick();
    checkOutput("cyc3_fs", frame_start, 1'b0);
    tick();
    checkOutput("cyc4_bclk", i2s_bclk, 1'b0);
    checkOutput("cyc4_fs", frame_start, 1'b1);
    checkOutput("cyc4_ur", underrun, 1'b1);
    checkOutput("cyc4_lrclk", i2s_lrclk, 1'b0);

    $display("[TB] idle frame, pushing 0x800001");
    collectFrame(1'b1, 24'h800001, d, lr, ur);
    checkOutput("idle_data", d, 64'h0);
    checkOutput("idle_ur", ur, 1'b0);
    checkOutput("held_ready", sample_ready, 1'b0);
    waitFrame(n);
    checkOutput("period_a", 64'(n), 64'd4);
    checkOutput("load_ur", underrun, 1'b0);
    checkOutput("load_ready", sample_ready, 1'b1);

    $display("[TB] frame 0x800001, pushing 0x7FFFFF");
    collectFrame(1'b1, 24'h7FFFFF, d, lr, ur);
    checkOutput("frame_800001", d, 64'h40000080_40000080);
    checkOutput("lrclk_pattern", lr, 64'h00000000_FFFFFFFF);
    checkOutput("frame_b_ur", ur, 1'b0);
    waitFrame(n);
    checkOutput("period_b", 64'(n), 64'd4);
    checkOutput("load_c_ur", underrun, 1'b0);
    collectFrame(1'b0, 24'h0, d, lr, ur);
    checkOutput("frame_7fffff", d, 64'h3FFFFF80_3FFFFF80);

    $display("[TB] starved frame repeats last sample");
    waitFrame(n);
    checkOutput("starve_fs", frame_start, 1'b1);
    checkOutput("starve_ur", underrun, 1'b1);
    collectFrame(1'b0, 24'h0, d, lr, ur);
    checkOutput("repeat_data", d, 64'h3FFFFF80_3FFFFF80);
    checkOutput("repeat_ur_once", ur, 1'b0);

    $display("[TB] overflow and boundary capture");
    waitFrame(n);
    checkOutput("e_ur", underrun, 1'b1);
    applyStimulus(24'h123456);
    applyStimulus(24'h654321);
    checkOutput("ovf_one", overflow_cnt, 8'd1);
    checkOutput("ovf_ready", sample_ready, 1'b0);
    repeat (253) tick();
    applyStimulus(24'hABCDEF);
    checkOutput("bnd_fs", frame_start, 1'b1);
    checkOutput("bnd_ur", underrun, 1'b0);
    checkOutput("bnd_ovf", overflow_cnt, 8'd1);
    checkOutput("bnd_ready", sample_ready, 1'b0);
    collectFrame(1'b0, 24'h0, d, lr, ur);
    checkOutput("frame_123456", d, 64'h091A2B00_091A2B00);
    waitFrame(n);
    checkOutput("g_ur", underrun, 1'b0);
    collectFrame(1'b0, 24'h0, d, lr, ur);
    checkOutput("frame_abcdef", d, 64'h55E6F780_55E6F780);

    $display("[TB] overflow saturation");
    waitFrame(n);
    checkOutput("h_ur", underrun, 1'b1);
    for (int i = 0; i < 301; i++) applyStimulus(24'($urandom));
    checkOutput("ovf_sat", overflow_cnt, 8'd255);
    checkOutput("sat_ready", sample_ready, 1'b0);

    $display("[TB] asynchronous reset mid-frame");
    repeat (37) tick();
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("arst_bclk", i2s_bclk, 1'b0);
    checkOutput("arst_lrclk", i2s_lrclk, 1'b1);
    checkOutput("arst_sdata", i2s_sdata, 1'b0);
    checkOutput("arst_ready", sample_ready, 1'b1);
    checkOutput("arst_ovf", overflow_cnt, 8'd0);
    checkOutput("arst_fs", frame_start, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rstn = 1'b1;
    waitFrame(n);
    checkOutput("post_rst_period", 64'(n), 64'd4);
    checkOutput("post_rst_ur", underrun, 1'b1);
    collectFrame(1'b0, 24'h0, d, lr, ur);
    checkOutput("post_rst_data", d, 64'h0);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
